// File: rtl/avr_cpu_pkg.sv
// Shared AVR core definitions: register-file geometry, debug op codes and
// the debug-port state encoding.
package avr_cpu_pkg;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned REG_IDX_W = $clog2(NUM_REGS);

    localparam logic OP_DUMP = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HALT_WAIT = 3'd1,
        ST_DUMP      = 3'd2,
        ST_LOAD      = 3'd3,
        ST_RELEASE   = 3'd4
    } dbg_state_e;

endpackage

// File: rtl/avr_cpu_reg_debug_if.sv
// Bundle of command, core-halt, register-file and byte-stream signals of the
// register debug port.
interface avr_cpu_reg_debug_if;
    import avr_cpu_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    reg_idx_t   cmd_first;
    reg_idx_t   cmd_count;
    logic       cpu_halt;
    logic       cpu_halted;
    reg_idx_t   rf_addr;
    logic [7:0] rf_rdata;
    logic [7:0] rf_wdata;
    logic       rf_write;
    logic       dout_valid;
    logic       dout_ready;
    logic [7:0] dout_data;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] din_data;
    logic       busy;
    logic       done;
    logic       error;

    modport slave (
        input  cmd_valid, cmd_op, cmd_first, cmd_count, cpu_halted, rf_rdata,
               dout_ready, din_valid, din_data,
        output cmd_ready, cpu_halt, rf_addr, rf_wdata, rf_write, dout_valid,
               dout_data, din_ready, busy, done, error
    );

    modport master (
        output cmd_valid, cmd_op, cmd_first, cmd_count, cpu_halted, rf_rdata,
               dout_ready, din_valid, din_data,
        input  cmd_ready, cpu_halt, rf_addr, rf_wdata, rf_write, dout_valid,
               dout_data, din_ready, busy, done, error
    );

endinterface

// File: rtl/avr_cpu_timeout.sv
// Cycle counter for the halt handshake; expired rises on the LIMIT-th
// consecutive cycle with clear low.
module avr_cpu_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic expired
);
    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/avr_cpu_reg_debug.sv
// Register debug port: halts the AVR core, then streams a wrapping window of
// the register file out (dump) or in (load), one byte per cycle.
module avr_cpu_reg_debug
    import avr_cpu_pkg::*;
#(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    avr_cpu_reg_debug_if.slave bus
);
    dbg_state_e state_q, state_d;
    logic       op_q, op_d;
    reg_idx_t   addr_q, addr_d;
    reg_idx_t   remaining_q, remaining_d;
    logic       err_q, err_d;
    logic       not_halt_wait;
    logic       halt_expired;
    logic       xfer;

    assign not_halt_wait = (state_q != ST_HALT_WAIT);

    avr_cpu_timeout #(.LIMIT(HALT_TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (not_halt_wait),
        .expired (halt_expired)
    );

    // Strobes are qualified by rst_n so a reset cycle aborts without a final write or done.
    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.cpu_halt   = (state_q == ST_HALT_WAIT) || (state_q == ST_DUMP) ||
                            (state_q == ST_LOAD);
    assign bus.dout_valid = rst_n && (state_q == ST_DUMP);
    assign bus.dout_data  = bus.dout_valid ? bus.rf_rdata : '0;
    assign bus.din_ready  = rst_n && (state_q == ST_LOAD);
    assign bus.rf_write   = bus.din_ready && bus.din_valid;
    assign bus.rf_wdata   = bus.rf_write ? bus.din_data : '0;
    assign bus.rf_addr    = addr_q;
    assign bus.done       = rst_n && (state_q == ST_RELEASE);
    assign bus.error      = bus.done && err_q;

    assign xfer = (bus.dout_valid && bus.dout_ready) || bus.rf_write;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d        = bus.cmd_op;
                    addr_d      = bus.cmd_first;
                    remaining_d = bus.cmd_count;
                    err_d       = 1'b0;
                    state_d     = ST_HALT_WAIT;
                end
            end
            ST_HALT_WAIT: begin
                if (bus.cpu_halted) begin
                    state_d = (op_q == OP_LOAD) ? ST_LOAD : ST_DUMP;
                end else if (halt_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_DUMP, ST_LOAD: begin
                if (xfer) begin
                    if (remaining_q == '0) begin
                        state_d = ST_RELEASE;
                    end else begin
                        addr_d      = addr_q + reg_idx_t'(1);
                        remaining_d = remaining_q - reg_idx_t'(1);
                    end
                end
            end
            ST_RELEASE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_DUMP;
            addr_q      <= '0;
            remaining_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_avr_cpu_reg_debug.sv
// Self-checking bench for avr_cpu_reg_debug: directed and randomized dump/load
// commands checked against a register-window reference model.
module tb_avr_cpu_reg_debug;
    import avr_cpu_pkg::*;

    localparam int unsigned TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    avr_cpu_reg_debug_if bus ();

    avr_cpu_reg_debug #(.HALT_TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register-file model behind the port.
    logic [7:0] mem [32];
    assign bus.rf_rdata = mem[bus.rf_addr];

    int total = 0;
    int passed = 0;
    int failed = 0;

    int wr_cnt = 0, busy_cyc = 0, halt_cyc = 0, done_cnt = 0, err_cnt = 0;
    int err_alone = 0, halt_in_done = 0, ready_busy = 0, hold_bad = 0;
    logic [7:0] dump_q [$];
    logic [4:0] dump_addr_q [$];
    logic [7:0] fixed_q [$];
    logic       stalled = 1'b0;
    logic [4:0] st_addr;
    logic [7:0] st_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        end
        if (bus.rf_write) begin
            mem[bus.rf_addr] = bus.rf_wdata;
            wr_cnt++;
        end
        if (bus.dout_valid && bus.dout_ready) begin
            dump_q.push_back(bus.dout_data);
            dump_addr_q.push_back(bus.rf_addr);
        end
        if (stalled && bus.dout_valid && (bus.rf_addr !== st_addr || bus.dout_data !== st_data))
            hold_bad++;
        stalled = bus.dout_valid && !bus.dout_ready;
        st_addr = bus.rf_addr;
        st_data = bus.dout_data;
        if (bus.busy) busy_cyc++;
        if (bus.cpu_halt) halt_cyc++;
        if (bus.done) done_cnt++;
        if (bus.error) err_cnt++;
        if (bus.error && !bus.done) err_alone++;
        if (bus.done && bus.cpu_halt) halt_in_done++;
        if (bus.busy && bus.cmd_ready) ready_busy++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic run_cmd(input string name, input logic op, input logic [4:0] first,
                           input logic [4:0] count, input int halt_delay, input int stall_mode,
                           input bit drop_halt, input bit hold_cmd, input bit expect_timeout);
        logic [7:0] snap [32];
        logic [7:0] expect_mem [32];
        logic [7:0] din_bytes [$];
        int n, b0, h0, d0, e0, w0, q0, hb0, rb0, ea0, hd0, din_i, mism;
        bit got_done, rdy;
        n = int'(count) + 1;
        snap = mem;
        din_bytes = {};
        for (int i = 0; i < n; i++)
            din_bytes.push_back((fixed_q.size() == n) ? fixed_q[i] : 8'($urandom));
        expect_mem = snap;
        if (op == OP_LOAD && !expect_timeout)
            for (int i = 0; i < n; i++) expect_mem[(int'(first) + i) % 32] = din_bytes[i];
        b0 = busy_cyc; h0 = halt_cyc; d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        q0 = dump_q.size(); hb0 = hold_bad; rb0 = ready_busy; ea0 = err_alone; hd0 = halt_in_done;

        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = op;
        bus.cmd_first  = first;
        bus.cmd_count  = count;
        bus.cpu_halted = (halt_delay == 0);
        bus.dout_ready = 1'b0;
        bus.din_valid  = 1'b0;
        #1;
        chk({name, "_accept_ready"}, 32'(bus.cmd_ready), 1);
        cyc();
        if (hold_cmd) begin
            bus.cmd_first = first + 5'd7;
            bus.cmd_op    = ~op;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        got_done = 1'b0;
        din_i = 0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            if (drop_halt && c > halt_delay) bus.cpu_halted = 1'($urandom_range(1));
            else bus.cpu_halted = (c >= halt_delay);
            case (stall_mode)
                0: rdy = 1'b1;
                1: rdy = (c % 4 == 0) || (c % 4 == 3);
                default: rdy = 1'($urandom_range(1));
            endcase
            bus.dout_ready = rdy;
            bus.din_valid  = rdy && (din_i < n);
            bus.din_data   = (din_i < n) ? din_bytes[din_i] : 8'h00;
            #1;
            if (bus.din_valid && bus.din_ready) din_i++;
            if (bus.done) begin
                got_done = 1'b1;
                bus.cmd_valid = 1'b0;
            end else begin
                cyc();
            end
        end
        chk({name, "_done_seen"}, 32'(got_done), 1);
        cyc();
        bus.dout_ready = 1'b0;
        bus.din_valid  = 1'b0;
        #1;
        chk({name, "_idle_ready"}, 32'(bus.cmd_ready), 1);
        chk({name, "_idle_busy"}, 32'(bus.busy), 0);
        if (stall_mode == 0)
            chk({name, "_busy_cycles"}, busy_cyc - b0,
                expect_timeout ? TIMEOUT + 1 : halt_delay + 1 + n + 1);
        chk({name, "_halt_span"}, halt_cyc - h0, busy_cyc - b0 - 1);
        chk({name, "_done_pulses"}, done_cnt - d0, 1);
        chk({name, "_error_pulses"}, err_cnt - e0, expect_timeout ? 1 : 0);
        chk({name, "_error_without_done"}, err_alone - ea0, 0);
        chk({name, "_halt_during_done"}, halt_in_done - hd0, 0);
        chk({name, "_ready_while_busy"}, ready_busy - rb0, 0);
        chk({name, "_writes"}, wr_cnt - w0, (op == OP_LOAD && !expect_timeout) ? n : 0);
        mism = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== expect_mem[i]) mism++;
        chk({name, "_regfile"}, mism, 0);
        chk({name, "_dump_len"}, dump_q.size() - q0, (op == OP_DUMP && !expect_timeout) ? n : 0);
        if (op == OP_DUMP && !expect_timeout && dump_q.size() - q0 == n) begin
            mism = 0;
            for (int i = 0; i < n; i++) begin
                if (dump_q[q0 + i] !== snap[(int'(first) + i) % 32]) mism++;
                if (dump_addr_q[q0 + i] !== 5'((int'(first) + i) % 32)) mism++;
            end
            chk({name, "_dump_bytes"}, mism, 0);
            chk({name, "_stall_hold"}, hold_bad - hb0, 0);
        end
        fixed_q = {};
    endtask

    initial begin
        int w0, d0;
        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_op     = 1'b0;
        bus.cmd_first  = '0;
        bus.cmd_count  = '0;
        bus.cpu_halted = 1'b0;
        bus.dout_ready = 1'b0;
        bus.din_valid  = 1'b0;
        bus.din_data   = '0;
        repeat (3) cyc();
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_cpu_halt", 32'(bus.cpu_halt), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_error", 32'(bus.error), 0);
        chk("rst_rf_write", 32'(bus.rf_write), 0);
        chk("rst_dout_valid", 32'(bus.dout_valid), 0);
        chk("rst_din_ready", 32'(bus.din_ready), 0);
        chk("rst_rf_addr", 32'(bus.rf_addr), 0);
        rst_n = 1'b1;
        cyc();

        run_cmd("dump_all", OP_DUMP, 5'd0, 5'd31, 0, 0, 1'b0, 1'b0, 1'b0);

        fixed_q = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_cmd("load_wrap", OP_LOAD, 5'd30, 5'd3, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("load_wrap_r30", 32'(mem[30]), 32'h A1);
        chk("load_wrap_r31", 32'(mem[31]), 32'h B2);
        chk("load_wrap_r0", 32'(mem[0]), 32'h C3);
        chk("load_wrap_r1", 32'(mem[1]), 32'h D4);

        run_cmd("dump_stall", OP_DUMP, 5'($urandom), 5'd9, 1, 1, 1'b0, 1'b0, 1'b0);
        run_cmd("halt_timeout", OP_LOAD, 5'd5, 5'd3, 1000, 0, 1'b0, 1'b0, 1'b1);

        // Reset lands on the third byte of a load.
        w0 = wr_cnt;
        d0 = done_cnt;
        bus.cmd_valid  = 1'b1;
        bus.cmd_op     = OP_LOAD;
        bus.cmd_first  = 5'($urandom);
        bus.cmd_count  = 5'd7;
        bus.cpu_halted = 1'b1;
        bus.din_valid  = 1'b1;
        bus.din_data   = 8'h11;
        cyc();
        bus.cmd_valid = 1'b0;
        cyc();
        #1;
        chk("rstmid_first_write", 32'(bus.rf_write), 1);
        cyc();
        bus.din_data = 8'h22;
        cyc();
        bus.din_data = 8'h33;
        rst_n = 1'b0;
        #1;
        chk("rstmid_no_third_write", 32'(bus.rf_write), 0);
        cyc();
        rst_n = 1'b1;
        bus.din_valid = 1'b0;
        #1;
        chk("rstmid_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rstmid_busy", 32'(bus.busy), 0);
        chk("rstmid_cpu_halt", 32'(bus.cpu_halt), 0);
        repeat (3) cyc();
        chk("rstmid_write_count", wr_cnt - w0, 2);
        chk("rstmid_no_done", done_cnt - d0, 0);

        run_cmd("busy_ignore", OP_DUMP, 5'd12, 5'd5, 2, 2, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_cmd($sformatf("rand%0d", k), 1'($urandom_range(1)), 5'($urandom),
                    5'($urandom_range(31)), int'($urandom_range(3)), int'($urandom_range(2)),
                    1'($urandom_range(1)), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
